alu_issue_ctrl: RTL

//  Initiator side of the combinational vector ALU: accepts one decoded R-type instruction via valid/ready,

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/vrf_32x64.sv | 51 +++++
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the vector ALU issue controller.
// Bus bit 0 (instruction/data MSB) maps to the top bit of each descending SV vector.
package alu_pkg;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = $clog2(NREGS);
    localparam int unsigned DW     = 64;
    localparam int unsigned NBYTES = DW / 8;

    localparam logic [5:0] OPC_RTYPE = 6'b101010;

    typedef enum logic [5:0] {
        VNOP   = 6'b000000, VAND   = 6'b000001, VOR    = 6'b000010, VXOR   = 6'b000011,
        VNOT   = 6'b000100, VMOV   = 6'b000101, VADD   = 6'b000110, VSUB   = 6'b000111,
        VMULEU = 6'b001000, VMULOU = 6'b001001, VSLL   = 6'b001010, VSRL   = 6'b001011,
        VSRA   = 6'b001100, VRTTH  = 6'b001101, VDIV   = 6'b001110, VMOD   = 6'b001111,
        VSQEU  = 6'b010000, VSQOU  = 6'b010001, VSQRT  = 6'b010010
    } func_e;

    typedef enum logic [2:0] {
        PPP_ALL  = 3'b000,
        PPP_HI   = 3'b001,
        PPP_LO   = 3'b010,
        PPP_EVEN = 3'b011,
        PPP_ODD  = 3'b100
    } ppp_e;

    typedef enum logic [1:0] {
        WW_8 = 2'b00, WW_16 = 2'b01, WW_32 = 2'b10, WW_64 = 2'b11
    } ww_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    // Field order = instruction bits [0:5],[6:10],[11:15],[16:20],[21:23],[24:25],[26:31]
    typedef struct packed {
        logic [5:0]    opcode;
        logic [AW-1:0] rd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [2:0]    ppp;
        logic [1:0]    ww;
        logic [5:0]    func;
    } instr_t;

    // Byte enable bit k covers data[8k+7:8k]; bus byte 0 is the top byte (k=7).
    function automatic logic [NBYTES-1:0] lane_mask(input logic [2:0] ppp);
        case (ppp)
            PPP_ALL:  lane_mask = 8'hFF;
            PPP_HI:   lane_mask = 8'hF0;
            PPP_LO:   lane_mask = 8'h0F;
            PPP_EVEN: lane_mask = 8'hAA;
            PPP_ODD:  lane_mask = 8'h55;
            default:  lane_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/vrf_32x64.sv
// 32x64 vector register file: two registered read ports, byte-enabled write port,
// combinational debug read port; synchronous reset clears every register.
module vrf_32x64
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     ra_addr_i,
    input  logic [AW-1:0]     rb_addr_i,
    output logic [DW-1:0]     ra_data_o,
    output logic [DW-1:0]     rb_data_o,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [NBYTES-1:0] wbe_i,
    input  logic [DW-1:0]     wd_i,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DW-1:0]     dbg_rdata_c_o
);

    logic [DW-1:0] mem_q [NREGS];
    logic [DW-1:0] ra_data_q;
    logic [DW-1:0] rb_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            ra_data_q <= '0;
            rb_data_q <= '0;
        end else begin
            if (we_i) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wbe_i[b]) begin
                        mem_q[wa_i][8*b +: 8] <= wd_i[8*b +: 8];
                    end
                end
            end
            if (rd_en_i) begin
                ra_data_q <= mem_q[ra_addr_i];
                rb_data_q <= mem_q[rb_addr_i];
            end
        end
    end

    assign ra_data_o     = ra_data_q;
    assign rb_data_o     = rb_data_q;
    assign dbg_rdata_c_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational vector ALU: accept, read operands,
// capture result, write back under the PPP byte-lane mask. One instruction per 4 cycles.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [DW-1:0] alu_rA,
    output logic [DW-1:0] alu_rB,
    output logic [5:0]    alu_op,
    output logic [5:0]    alu_R_ins,
    output logic [1:0]    alu_WW,
    input  logic [DW-1:0] alu_out,
    output logic          done,
    output logic          err,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata
);

    logic [1:0]    state_q, state_d;
    instr_t        instr_q, instr_d;
    logic [DW-1:0] result_q, result_d;
    logic [5:0]    op_q, op_d, func_q, func_d;
    logic [1:0]    ww_q, ww_d;
    logic          done_q, done_d, err_q, err_d;
    logic          rd_en, accept, illegal, wb_write;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [NBYTES-1:0] rf_wbe;
    logic [DW-1:0] rf_wd;

    assign instr_ready = (state_q == S_IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign illegal     = (instr_q.opcode != OPC_RTYPE) || (instr_q.ppp > PPP_ODD);
    assign wb_write    = (state_q == S_WB) && !illegal && (instr_q.func != VNOP);

    // Write-back owns the write port in WB; debug writes only land while idle.
    assign rf_we  = wb_write || ((state_q == S_IDLE) && dbg_we);
    assign rf_wa  = wb_write ? instr_q.rd : dbg_addr;
    assign rf_wbe = wb_write ? lane_mask(instr_q.ppp) : '1;
    assign rf_wd  = wb_write ? result_q : dbg_wdata;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        result_d = result_q;
        op_d     = op_q;
        func_d   = func_q;
        ww_d     = ww_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rd_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    instr_d = instr_t'(instr);
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_en   = 1'b1;
                op_d    = instr_q.opcode;
                func_d  = instr_q.func;
                ww_d    = instr_q.ww;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_out;
                done_d   = 1'b1;
                err_d    = illegal;
                state_d  = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            result_q <= '0;
            op_q     <= '0;
            func_q   <= '0;
            ww_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            op_q     <= op_d;
            func_q   <= func_d;
            ww_q     <= ww_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    vrf_32x64 u_vrf (
        .clk           (clk),
        .reset         (reset),
        .rd_en_i       (rd_en),
        .ra_addr_i     (instr_q.ra),
        .rb_addr_i     (instr_q.rb),
        .ra_data_o     (alu_rA),
        .rb_data_o     (alu_rB),
        .we_i          (rf_we),
        .wa_i          (rf_wa),
        .wbe_i         (rf_wbe),
        .wd_i          (rf_wd),
        .dbg_addr_i    (dbg_addr),
        .dbg_rdata_c_o (dbg_rdata)
    );

    assign alu_op    = op_q;
    assign alu_R_ins = func_q;
    assign alu_WW    = ww_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
